// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: store-fed TX FIFO, programmable baud divisor,
// and data_mem-compatible sub-word loads of STATUS/DIVISOR.
module uart_tx_mmio #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  memType,
    input  logic [63:0] addr,
    input  logic [63:0] wd,
    output logic [63:0] rd,
    output logic        txd,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} txState_t;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   fifoCount;
    logic          overflow;
    logic [15:0]   divisor;

    txState_t      state, stateNext;
    logic [15:0]   baudCnt, baudNext;
    logic [15:0]   curDiv, curDivNext;
    logic [2:0]    bitIdx, bitNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          txdNext;
    logic          popS;

    logic          wrEn, pushReq, pushAcc, pushDrop, fifoRoom;
    logic          fifoEmpty, fifoFull, bitEnd;
    logic [1:0]    regSel;
    logic [15:0]   divEff;
    logic [63:0]   regVal, shifted, rdLoad;
    logic          unusedOk;

    assign regSel    = addr[4:3];
    assign wrEn      = sel & we;
    assign fifoEmpty = (fifoCount == {(AW+1){1'b0}});
    assign fifoFull  = (fifoCount == CNT_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign fifoRoom  = !fifoFull || popS;
    assign pushReq   = wrEn && (regSel == 2'd0);
    assign pushAcc   = pushReq && fifoRoom;
    assign pushDrop  = pushReq && !fifoRoom;
    assign divEff    = (divisor == 16'd0) ? 16'd1 : divisor;
    assign bitEnd    = (baudCnt == (curDiv - 16'd1));
    assign tx_busy   = (state != IDLE) || !fifoEmpty;
    assign unusedOk  = ^{addr[63:5], wd[63:16]};

    // TX FIFO storage, pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr     <= {AW{1'b0}};
            rdPtr     <= {AW{1'b0}};
            fifoCount <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem[i] <= 8'h00;
            end
        end else begin
            if (pushAcc) begin
                fifoMem[wrPtr] <= wd[7:0];
                wrPtr          <= wrPtr + PTR_ONE;
            end
            if (popS) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({pushAcc, popS})
                2'b10:   fifoCount <= fifoCount + CNT_ONE;
                2'b01:   fifoCount <= fifoCount - CNT_ONE;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky overflow flag and baud divisor register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            divisor  <= DIV_RESET[15:0];
        end else begin
            if (pushDrop) begin
                overflow <= 1'b1;
            end else if (wrEn && (regSel == 2'd1) && wd[2]) begin
                overflow <= 1'b0;
            end
            // Byte stores (B/BU) leave the divisor untouched.
            if (wrEn && (regSel == 2'd2) && (memType[1:0] != 2'b00)) begin
                divisor <= wd[15:0];
            end
        end
    end

    // Serialiser state register; txd is registered from the next-state view
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baudCnt  <= 16'd0;
            curDiv   <= DIV_RESET[15:0];
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
            txd      <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            curDiv   <= curDivNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txd      <= txdNext;
        end
    end

    // Serialiser next-state logic; the divisor is resampled at every bit boundary
    always_comb begin
        stateNext  = state;
        baudNext   = baudCnt;
        curDivNext = curDiv;
        bitNext    = bitIdx;
        shiftNext  = shiftReg;
        popS       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    popS       = 1'b1;
                    shiftNext  = fifoMem[rdPtr];
                    baudNext   = 16'd0;
                    curDivNext = divEff;
                    stateNext  = START;
                end else begin
                    stateNext  = IDLE;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudNext   = 16'd0;
                    curDivNext = divEff;
                    bitNext    = 3'd0;
                    stateNext  = DATA;
                end else begin
                    baudNext   = baudCnt + 16'd1;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudNext   = 16'd0;
                    curDivNext = divEff;
                    shiftNext  = {1'b0, shiftReg[7:1]};
                    bitNext    = bitIdx + 3'd1;
                    stateNext  = (bitIdx == 3'd7) ? STOP : DATA;
                end else begin
                    baudNext   = baudCnt + 16'd1;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    baudNext   = 16'd0;
                    curDivNext = divEff;
                    if (!fifoEmpty) begin
                        popS      = 1'b1;
                        shiftNext = fifoMem[rdPtr];
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext   = baudCnt + 16'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        case (stateNext)
            START:   txdNext = 1'b0;
            DATA:    txdNext = shiftNext[0];
            default: txdNext = 1'b1;
        endcase
    end

    // Load path: register select, byte shift, then data_mem-style extension
    always_comb begin
        case (regSel)
            2'd1:    regVal = {56'd0, 4'(fifoCount), 1'b0, overflow, fifoEmpty, fifoFull};
            2'd2:    regVal = {48'd0, divisor};
            default: regVal = 64'd0;
        endcase
        shifted = regVal >> {addr[2:0], 3'b000};
        case (memType)
            3'b000:  rdLoad = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  rdLoad = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  rdLoad = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  rdLoad = shifted;
            3'b100:  rdLoad = {56'd0, shifted[7:0]};
            3'b101:  rdLoad = {48'd0, shifted[15:0]};
            3'b110:  rdLoad = {32'd0, shifted[31:0]};
            default: rdLoad = 64'd0;
        endcase
        if (sel) begin
            rd = rdLoad;
        end else begin
            rd = 64'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register access, frame timing,
// FIFO overflow, back-to-back frames, sub-word loads and mid-frame reset.
module tb_uart_tx_mmio;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [2:0]  memType;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    logic        txd;
    logic        tx_busy;

    int nChecks = 0;
    int nPass   = 0;
    int cycCnt  = 0;

    uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(868)) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .we      (we),
        .memType (memType),
        .addr    (addr),
        .wd      (wd),
        .rd      (rd),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic doStore(input logic [63:0] a, input logic [63:0] d, input logic [2:0] t);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wd = d; memType = t;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    // Pushes n bytes base, base+1, ... on consecutive edges; returns at the negedge after the last.
    task automatic pushBurst(input int n, input logic [7:0] base);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sel = 1'b1; we = 1'b1; addr = 64'h0; memType = 3'b000;
            wd = {56'd0, base + 8'(i)};
            @(negedge clk);
        end
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic doLoad(input logic [63:0] a, input logic [2:0] t, output logic [63:0] v);
        sel = 1'b1; we = 1'b0; addr = a; memType = t;
        #1 v = rd;
        sel = 1'b0;
    endtask

    // Samples txd at the current negedge and the following n-1 negedges, then advances once more.
    task automatic captureTxd(input int n, output logic [63:0] v);
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            v[i] = txd;
            @(negedge clk);
        end
    endtask

    // seq[0] is the start bit, seq[9] the stop bit; each lasts div cycles.
    function automatic logic [63:0] frameBits(input logic [9:0] seq, input int div);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < div; c++) begin
                v[i*div + c] = seq[i];
            end
        end
        return v;
    endfunction

    logic [63:0] v;
    logic [63:0] exp;
    int          c10;
    int          k;
    logic        stayedIdle;

    initial begin
        reset = 1'b0; sel = 1'b0; we = 1'b0; memType = 3'b000; addr = 64'd0; wd = 64'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // reset state
        checkEq("reset_txd", {63'd0, txd}, 64'd1);
        checkEq("reset_busy", {63'd0, tx_busy}, 64'd0);
        doLoad(64'h08, 3'b011, v); checkEq("reset_status", v, 64'h2);
        doLoad(64'h10, 3'b011, v); checkEq("reset_divisor", v, 64'd868);
        doLoad(64'h08, 3'b011, v);
        sel = 1'b0; #1 checkEq("unselected_rd", rd, 64'd0);

        // single frame 0xA5, div 4
        doStore(64'h10, 64'd4, 3'b011);
        pushBurst(1, 8'hA5);
        checkEq("a5_busy_queued", {63'd0, tx_busy}, 64'd1);
        @(negedge clk);
        captureTxd(40, v);
        checkEq("a5_frame", v, frameBits(10'b1_1010_0101_0, 4));
        checkEq("a5_busy_after", {63'd0, tx_busy}, 64'd0);
        checkEq("a5_txd_after", {63'd0, txd}, 64'd1);

        // overflow with 10 consecutive pushes, div 2
        doStore(64'h10, 64'd2, 3'b001);
        pushBurst(10, 8'h30);
        c10 = cycCnt;
        doLoad(64'h08, 3'b011, v); checkEq("ovf_status", v, 64'h85);
        doLoad(64'h08, 3'b000, v); checkEq("ovf_status_b", v, 64'hFFFF_FFFF_FFFF_FF85);
        doStore(64'h08, 64'h4, 3'b011);
        doLoad(64'h08, 3'b011, v); checkEq("ovf_cleared", v, 64'h81);
        k = 0;
        while (tx_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkEq("drain_cycles", 64'(cycCnt - c10), 64'd172);
        doLoad(64'h08, 3'b011, v); checkEq("drain_status", v, 64'h2);

        // back-to-back 0x41, 0x42, div 3
        doStore(64'h10, 64'd3, 3'b010);
        pushBurst(2, 8'h41);
        captureTxd(60, v);
        exp = frameBits(10'b1_0100_0001_0, 3) | (frameBits(10'b1_0100_0010_0, 3) << 30);
        checkEq("b2b_frames", v, exp);
        checkEq("b2b_busy_after", {63'd0, tx_busy}, 64'd0);

        // sub-word loads of DIVISOR and ignored byte store
        doStore(64'h10, 64'h0080, 3'b011);
        doLoad(64'h10, 3'b000, v); checkEq("div_load_b", v, 64'hFFFF_FFFF_FFFF_FF80);
        doLoad(64'h10, 3'b100, v); checkEq("div_load_bu", v, 64'h80);
        doLoad(64'h10, 3'b001, v); checkEq("div_load_h", v, 64'h80);
        doLoad(64'h11, 3'b100, v); checkEq("div_load_bu_off1", v, 64'h0);
        doLoad(64'h00, 3'b011, v); checkEq("txdata_reads_zero", v, 64'h0);
        doStore(64'h10, 64'h5, 3'b000);
        doLoad(64'h10, 3'b011, v); checkEq("div_byte_store_ignored", v, 64'h80);

        // divisor 0 behaves as 1
        doStore(64'h10, 64'd0, 3'b011);
        doLoad(64'h10, 3'b011, v); checkEq("div_zero_readback", v, 64'h0);
        pushBurst(1, 8'h0F);
        @(negedge clk);
        captureTxd(10, v);
        checkEq("div_zero_frame", v, frameBits(10'b1_0000_1111_0, 1));
        checkEq("div_zero_busy_after", {63'd0, tx_busy}, 64'd0);

        // reset in the middle of DATA
        doStore(64'h10, 64'd4, 3'b011);
        pushBurst(2, 8'h00);
        repeat (5) @(negedge clk);
        checkEq("pre_reset_data_bit", {63'd0, txd}, 64'd0);
        #2 reset = 1'b0;
        #1 checkEq("reset_async_txd", {63'd0, txd}, 64'd1);
        checkEq("reset_async_busy", {63'd0, tx_busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        doLoad(64'h08, 3'b011, v); checkEq("post_reset_status", v, 64'h2);
        doLoad(64'h10, 3'b011, v); checkEq("post_reset_divisor", v, 64'd868);
        stayedIdle = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!txd || tx_busy) stayedIdle = 1'b0;
        end
        checkEq("post_reset_idle", {63'd0, stayedIdle}, 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
